// File: rtl/shift_seq_ctrl.sv
// Sequencer for a 4-bit universal shift register: on start it loads a pattern,
// rotates it left N times, rotates it right N times, then pulses done.
module shift_seq_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       blank_i,
  input  logic [3:0] pat_i,
  input  logic [3:0] cnt_i,
  output logic       oe_o,
  output logic [1:0] s_o,
  output logic [3:0] d_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int DIV_W = $clog2(TICK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, LEFT, RIGHT, DONE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       k_q, k_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       n_q, n_d;
  logic [1:0]       s_q, s_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             oe_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    k_d     = k_q;
    pat_d   = pat_q;
    n_d     = n_q;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          pat_d   = pat_i;
          n_d     = cnt_i;
          div_d   = '0;
          k_d     = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort_i)           state_d = IDLE;
        else if (n_q == 4'd0)  state_d = DONE;
        else                   state_d = LEFT;
      end
      LEFT, RIGHT: begin
        if (abort_i) begin
          state_d = IDLE;
          div_d   = '0;
          k_d     = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          // n_q is at least 1 here, so n_q-1 never wraps and N=15 completes.
          if (k_q == n_q - 4'd1) begin
            k_d     = '0;
            state_d = (state_q == LEFT) ? RIGHT : DONE;
          end else begin
            k_d = k_q + 4'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next state so they land in registers aligned with it.
    s_d = 2'b00;
    case (state_d)
      LOAD:    s_d = 2'b11;
      LEFT:    if (div_d == DIV_LAST) s_d = 2'b01;
      RIGHT:   if (div_d == DIV_LAST) s_d = 2'b10;
      default: s_d = 2'b00;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      k_q     <= '0;
      pat_q   <= '0;
      n_q     <= '0;
      s_q     <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      k_q     <= k_d;
      pat_q   <= pat_d;
      n_q     <= n_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      oe_q    <= ~blank_i;
    end
  end

  assign oe_o   = oe_q;
  assign s_o    = s_q;
  assign d_o    = pat_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
